// File: rtl/kp_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package kp_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kp_state_t;

  typedef enum logic [1:0] {NONE, KEY, MULTI} kp_pass_t;

  typedef struct packed {
    kp_pass_t   kind;
    logic [3:0] code;
  } kp_pass_s;

  localparam logic [3:0] KP_COL0  = 4'b0111;
  localparam logic [3:0] KP_COL1  = 4'b1011;
  localparam logic [3:0] KP_COL2  = 4'b1101;
  localparam logic [3:0] KP_COL3  = 4'b1110;
  localparam logic [3:0] KP_NOKEY = 4'hF;

  // Legend indexed by {row, col}; row r is read on kpr[3-r].
  localparam logic [3:0] KP_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [3:0] kp_keymap(input logic [1:0] row, input logic [1:0] col);
    return KP_MAP[{row, col}];
  endfunction

endpackage

// File: rtl/kpdecode.sv
// Combinational decode of one driven column and the synchronised rows into a key code.
module kpdecode
  import kp_pkg::*;
(
  input  logic [3:0] kpc,
  input  logic [3:0] kpr,
  output logic       kphit,
  output logic       kpmulti,
  output logic [3:0] num
);

  logic [1:0] col, row;
  logic       colok;
  logic [2:0] nlow;

  always_comb begin
    colok = 1'b1;
    col   = 2'd0;
    case (kpc)
      KP_COL0: col = 2'd0;
      KP_COL1: col = 2'd1;
      KP_COL2: col = 2'd2;
      KP_COL3: col = 2'd3;
      default: colok = 1'b0;
    endcase
    row  = 2'd0;
    nlow = 3'd0;
    // descending walk leaves the lowest pressed row in `row`
    for (int r = 3; r >= 0; r--) begin
      if (!kpr[3-r]) row = 2'(r);
      nlow = nlow + {2'b00, ~kpr[3-r]};
    end
    kphit   = colok && (nlow != 3'd0);
    kpmulti = colok && (nlow > 3'd1);
    num     = kphit ? kp_keymap(row, col) : KP_NOKEY;
  end

endmodule

// File: rtl/kp_scan_ctrl.sv
// Keypad scanner: column drive, row sync, pass-level debounce, single-entry event register.
// Optional auto-repeat while held is compiled in with `define KP_REPEAT_EN.
module kp_scan_ctrl
  import kp_pkg::*;
#(
  parameter int SCAN_DIV   = 5000,
  parameter int DB_PASSES  = 4,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic       key_valid,
  output logic [3:0] key_num,
  input  logic       key_ready,
  output logic       overrun,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell;
  logic          tc, pass_end;
  logic [3:0]    rs1, rs2;
  logic          hit, multi;
  logic [3:0]    dnum;
  logic [1:0]    acc_n, col_n, tot_n;
  logic [2:0]    sum_n;
  logic [3:0]    acc_code;
  kp_pass_s      pres;
  logic          key_hit;
  kp_state_t     state, nstate;
  logic [3:0]    dbc, dbc_n, cand, cand_n;
  logic          emit, hs;

`ifdef KP_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + REPEAT_PER + 1);
  logic [RW-1:0] rpt, rpt_n;
`endif

  assign tc       = (dwell == DW'(SCAN_DIV - 1));
  assign pass_end = tc && (kpc == KP_COL3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell <= '0;
      kpc   <= KP_COL0;
      rs1   <= 4'hF;
      rs2   <= 4'hF;
    end else begin
      rs1   <= kpr;
      rs2   <= rs1;
      dwell <= tc ? '0 : dwell + DW'(1);
      if (tc) begin
        case (kpc)
          KP_COL0: kpc <= KP_COL1;
          KP_COL1: kpc <= KP_COL2;
          KP_COL2: kpc <= KP_COL3;
          default: kpc <= KP_COL0;
        endcase
      end
    end
  end

  kpdecode u_kpdecode (
    .kpc    (kpc),
    .kpr    (rs2),
    .kphit  (hit),
    .kpmulti(multi),
    .num    (dnum)
  );

  // Hit count saturates at 2: anything beyond one hit per pass is a ghost.
  always_comb begin
    col_n     = hit ? (multi ? 2'd2 : 2'd1) : 2'd0;
    sum_n     = {1'b0, acc_n} + {1'b0, col_n};
    tot_n     = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    pres.kind = (tot_n == 2'd0) ? NONE : (tot_n == 2'd1) ? KEY : MULTI;
    pres.code = (acc_n != 2'd0) ? acc_code : dnum;
    key_hit   = (pres.kind == KEY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_n    <= 2'd0;
      acc_code <= KP_NOKEY;
    end else if (tc) begin
      if (pass_end) begin
        acc_n    <= 2'd0;
        acc_code <= KP_NOKEY;
      end else begin
        acc_n <= tot_n;
        if (acc_n == 2'd0 && hit) acc_code <= dnum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dbc   <= 4'd0;
      cand  <= 4'd0;
`ifdef KP_REPEAT_EN
      rpt   <= '0;
`endif
    end else begin
      state <= nstate;
      dbc   <= dbc_n;
      cand  <= cand_n;
`ifdef KP_REPEAT_EN
      rpt   <= rpt_n;
`endif
    end
  end

  // dbc counts confirming passes in DEBOUNCE and quiet passes in RELEASE.
  always_comb begin
    nstate = state;
    dbc_n  = dbc;
    cand_n = cand;
    emit   = 1'b0;
`ifdef KP_REPEAT_EN
    rpt_n  = rpt;
`endif
    if (pass_end) begin
      case (state)
        IDLE: begin
          if (key_hit) begin
            cand_n = pres.code;
            dbc_n  = 4'd1;
            if (DB_PASSES == 1) begin
              emit   = 1'b1;
              nstate = HELD;
            end else begin
              nstate = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!key_hit) begin
            nstate = IDLE;
            dbc_n  = 4'd0;
          end else if (pres.code == cand) begin
            dbc_n = dbc + 4'd1;
            if (dbc_n == 4'(DB_PASSES)) begin
              emit   = 1'b1;
              nstate = HELD;
            end
          end else begin
            cand_n = pres.code;
            dbc_n  = 4'd1;
          end
        end
        HELD: begin
          if (!key_hit) begin
            if (DB_PASSES == 1) begin
              nstate = IDLE;
              dbc_n  = 4'd0;
`ifdef KP_REPEAT_EN
              rpt_n  = '0;
`endif
            end else begin
              nstate = RELEASE;
              dbc_n  = 4'd1;
            end
          end
`ifdef KP_REPEAT_EN
          else begin
            // count wraps back to DLY so later repeats land every PER passes
            rpt_n = rpt + RW'(1);
            if (rpt_n == RW'(REPEAT_DLY + REPEAT_PER)) begin
              emit  = 1'b1;
              rpt_n = RW'(REPEAT_DLY);
            end else if (rpt_n == RW'(REPEAT_DLY)) begin
              emit = 1'b1;
            end
          end
`endif
        end
        RELEASE: begin
          if (!key_hit) begin
            dbc_n = dbc + 4'd1;
            if (dbc_n == 4'(DB_PASSES)) begin
              nstate = IDLE;
              dbc_n  = 4'd0;
`ifdef KP_REPEAT_EN
              rpt_n  = '0;
`endif
            end
          end else begin
            nstate = HELD;
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    key_held = (state == HELD) || (state == RELEASE);
  end

  assign hs = key_valid && key_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_valid <= 1'b0;
      key_num   <= 4'd0;
      overrun   <= 1'b0;
    end else begin
      if (emit && (!key_valid || hs)) begin
        key_valid <= 1'b1;
        key_num   <= cand_n;
      end else if (hs) begin
        key_valid <= 1'b0;
      end
      if (hs)                     overrun <= 1'b0;
      else if (emit && key_valid) overrun <= 1'b1;
    end
  end

endmodule

// File: doc/kp_scan_ctrl.md
# kp_scan_ctrl

Keypad scan controller for the 4x4 matrix keypad. It drives the column lines one at a time and synchronises the row inputs. It decodes each column/row pair through an embedded `kpdecode` instance, debounces press and release over whole scan passes, and delivers one key event per press to the downstream control logic through a single-entry valid/ready holding register.

## Interface
Parameters:
- `SCAN_DIV`, 5000: clock cycles each column is driven (dwell); legal range ≥ 4.
- `DB_PASSES`, 4: consecutive identical full scan passes needed to accept a press or a release; range 1–15.
- `REPEAT_DLY`, 50: passes a key must stay held before the first auto-repeat (used only with `KP_REPEAT_EN`).
- `REPEAT_PER`, 10: passes between later auto-repeats (used only with `KP_REPEAT_EN`).

Ports:
- `clk`, in, 1: system clock.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `kpr`, in, 4: raw row inputs from the pins, active-low, asynchronous.
- `kpc`, out, 4: column drive, one-hot-low, registered.
- `key_valid`, out, 1: holding register contains an event.
- `key_num`, out, 4: hex code of the event, held stable while `key_valid` = 1.
- `key_ready`, in, 1: consumer accepts; a handshake occurs when `key_valid` && `key_ready`.
- `overrun`, out, 1: sticky flag; an event was dropped because the holding register was full.
- `key_held`, out, 1: the debounced key-down state (high in HELD and RELEASE).

## Operation
- **Column sequencing:**
  - `kpc` steps 0111 → 1011 → 1101 → 1110 → 0111. A dwell counter (0..`SCAN_DIV`-1) advances the column at terminal count.
  - `kpr` passes through a 2-flop synchroniser.
  - The decode of the synchronised `kpr` and the current `kpc` is sampled on the last cycle of each dwell.
- **Pass result:** four samples make one pass. The result is classified at the end of column 1110:
  - NONE: no hits.
  - KEY(code): exactly one hit.
  - MULTI: two or more hits. MULTI is treated as NONE (ghost rejection).
- **FSM** (all transitions are evaluated only at pass end):
  - IDLE:
    - KEY(k): set cand=k, cnt=1, go to DEBOUNCE. If `DB_PASSES`=1, emit immediately and go to HELD.
  - DEBOUNCE:
    - KEY(cand): cnt++. When cnt==`DB_PASSES`, emit cand and go to HELD.
    - KEY(other): set cand=other, cnt=1.
    - NONE: go to IDLE.
  - HELD:
    - NONE: rcnt=1, go to RELEASE. If `DB_PASSES`=1, go straight to IDLE.
    - Any KEY: stay in HELD. Keys other than cand are ignored; there is no rollover.
  - RELEASE:
    - NONE: rcnt++. When rcnt==`DB_PASSES`, go to IDLE.
    - Any KEY: go back to HELD without a new emit.
- **Emit:**
  - Holding register empty, or handshake in the same cycle: load `key_num`, `key_valid`=1.
  - Otherwise: drop the event and set `overrun`.
- **Handshake:** `key_valid` clears the cycle after a handshake unless a new event loads in that same cycle.
- **`overrun`** clears on the next handshake.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). Any pending event is lost.

## Timing
- Reset values:
  - `kpc`=0111, `key_valid`=0, `key_num`=0, `overrun`=0, `key_held`=0.
  - FSM=IDLE, counters=0, synchroniser=1111.
- One pass is 4·`SCAN_DIV` cycles.
- Row-to-sample latency is 2 cycles (synchroniser). For that reason `SCAN_DIV` ≥ 4 is required.
- Emit latency: `key_valid` rises 1 cycle after the end of the `DB_PASSES`-th confirming pass.
- `key_held` rises in the same cycle as the emit and falls 1 cycle after the final release pass.
- `kpc` changes 1 cycle after the dwell counter reaches terminal count.

## Configuration
- `KP_REPEAT_EN` defined:
  - HELD keeps a pass counter.
  - After `REPEAT_DLY` passes it re-emits cand, then re-emits every `REPEAT_PER` passes while HELD.
  - Entering RELEASE freezes the counter. Returning to IDLE clears it.
  - Re-emits follow the normal emit/overrun rules.
- `KP_REPEAT_EN` undefined: exactly one emit per press, and no repeat counter is present.

## Structure
- Package `kp_pkg` contains:
  - `kp_state_t` enum: IDLE, DEBOUNCE, HELD, RELEASE.
  - Column constants: `KP_COL0`..`KP_COL3` = 0111, 1011, 1101, 1110.
  - `KP_NOKEY` = 4'hF.
  - Pass-result enum: NONE, KEY, MULTI.
- Sub-module: one `kpdecode` instance, fed the synchronised rows and the registered `kpc`. Its `kphit`/`num` outputs are sampled at dwell end.

## Test plan
- **Single press:** `SCAN_DIV`=8, `DB_PASSES`=3. Hold the row0/col1 contact.
  - `key_valid` rises 1 cycle after the 3rd confirming pass end with `key_num`=2.
  - Exactly one event occurs. `key_held`=1 until 3 NONE passes after release.
- **Bounce:** toggle the contact every 5 cycles for 2 passes, then hold steady.
  - No emit during the bouncing.
  - One emit 3 passes after the contact stabilises.
- **Backpressure:** hold `key_ready`=0 and perform two separate presses ('5' then '9').
  - `key_num`=5 stays held and `overrun`=1.
  - Raising `key_ready` completes the handshake and clears `overrun`.
- **Ghost / second key:** press '1' and '6' in the same pass → no event. Press '1', then add '6' while HELD → only a '1' event.
- **Reset mid-debounce:** pull `reset_n` low during DEBOUNCE.
  - All outputs return to reset values immediately and `kpc`=0111.
  - After release, a steady key needs a full `DB_PASSES` again.
- **Auto-repeat** (`KP_REPEAT_EN`, `REPEAT_DLY`=4, `REPEAT_PER`=2, `key_ready`=1): hold 'A' → events at confirm, then +4 passes, then every 2 passes. They stop on release.
